// File: rtl/polyshift_r.sv
// Registered right barrel shifter: logical, arithmetic, double-precision
// (C_IN fill) and rotate, with one cycle of latency.
package utils_pkg;
  typedef enum logic [1:0] {
    LOGIC = 2'd0,
    ARITH = 2'd1,
    RCR   = 2'd2,
    ROR   = 2'd3
  } SHIFT_TYPE;
endpackage

module polyshift_r
  import utils_pkg::*;
#(
  parameter int unsigned word_width = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [word_width-1:0]         D_IN,
  input  logic [word_width-2:0]         C_IN,
  input  logic [$clog2(word_width)-1:0] shift_size,
  input  SHIFT_TYPE                     shift_type,
  output logic [word_width-1:0]         D_OUT
);

  localparam int unsigned SW = $clog2(word_width);
  localparam int unsigned VW = 2 * word_width - 1;

  logic [word_width-2:0] fill_c;
  logic [VW-1:0]         shift_vec_c;
  logic [word_width-1:0] result_c;
  logic [word_width-1:0] d_out_q;
  logic [word_width-1:0] d_out_d;

  // Bits that enter from the top; at most word_width-1 of them can ever land.
  always_comb begin
    fill_c = '0;
    case (shift_type)
      LOGIC:   fill_c = '0;
      ARITH:   fill_c = {(word_width-1){D_IN[word_width-1]}};
      RCR:     fill_c = C_IN;
      ROR:     fill_c = D_IN[word_width-2:0];
      default: fill_c = '0;
    endcase
  end

  // One stage per shift_size bit; stage k moves the fill/data vector by 2^k.
  always_comb begin
    shift_vec_c = {fill_c, D_IN};
    for (int unsigned k = 0; k < SW; k++) begin
      if (shift_size[k]) begin
        shift_vec_c = shift_vec_c >> (1 << k);
      end
    end
    result_c = shift_vec_c[word_width-1:0];
  end

  assign d_out_d = result_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign D_OUT = d_out_q;

endmodule

// File: tb/tb_polyshift_r.sv
// Scoreboard bench for polyshift_r at word_width = 8.
module tb_polyshift_r;
  import utils_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_in;
  logic [6:0] c_in;
  logic [2:0] shift_size;
  SHIFT_TYPE  shift_type;
  logic [7:0] d_out;

  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  polyshift_r #(.word_width(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D_IN       (d_in),
    .C_IN       (c_in),
    .shift_size (shift_size),
    .shift_type (shift_type),
    .D_OUT      (d_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_model(input SHIFT_TYPE t, input logic [7:0] d,
                                           input logic [6:0] c, input logic [2:0] s);
    logic [14:0] cat;
    logic [15:0] rot;
    logic [7:0]  r;
    case (t)
      LOGIC: r = d >> s;
      ARITH: r = 8'($signed(d) >>> s);
      RCR: begin
        cat = {c, d};
        cat = cat >> s;
        r   = cat[7:0];
      end
      default: begin
        rot = {d, d};
        rot = rot >> s;
        r   = rot[7:0];
      end
    endcase
    return r;
  endfunction

  task automatic drive(input SHIFT_TYPE t, input logic [7:0] d, input logic [6:0] c,
                       input logic [2:0] s, input logic [7:0] golden);
    shift_type = t;
    d_in       = d;
    c_in       = c;
    shift_size = s;
    exp_q.push_back(golden);
  endtask

  task automatic collect(input string tag);
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, d_out, 8'hxx);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, d_out, e);
    end
  endtask

  task automatic apply(input SHIFT_TYPE t, input logic [7:0] d, input logic [6:0] c,
                       input logic [2:0] s, input logic [7:0] golden, input string tag);
    @(negedge clk);
    drive(t, d, c, s, golden);
    collect(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    d_in       = 8'h00;
    c_in       = 7'h00;
    shift_size = 3'd0;
    shift_type = LOGIC;
    #2;
    check_eq("reset_async", d_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_held", d_out, 8'h00);

    // first edge after release loads the inputs present at that edge
    @(negedge clk);
    rst_n = 1'b1;
    drive(LOGIC, 8'b1001_0110, 7'h00, 3'd3, 8'b0001_0010);
    collect("logic_s3");

    apply(ARITH, 8'b1001_0110, 7'h00,        3'd3, 8'b1111_0010, "arith_neg_s3");
    apply(ARITH, 8'b0001_0110, 7'h00,        3'd3, 8'b0000_0010, "arith_pos_s3");
    apply(RCR,   8'b1001_0110, 7'b000_0101,  3'd3, 8'b1011_0010, "rcr_s3");
    apply(LOGIC, 8'b1001_0110, 7'b000_0101,  3'd3, 8'b0001_0010, "logic_cin_ignored");
    apply(ROR,   8'b1001_0110, 7'h00,        3'd3, 8'b1101_0010, "ror_s3");
    apply(ARITH, 8'b1001_0110, 7'b111_1111,  3'd3, 8'b1111_0010, "arith_cin_ignored");
    apply(ROR,   8'b1001_0110, 7'b111_1111,  3'd3, 8'b1101_0010, "ror_cin_ignored");

    for (int t = 0; t < 4; t++) begin
      apply(SHIFT_TYPE'(2'(t)), 8'b1001_0110, 7'b101_0101, 3'd0, 8'b1001_0110,
            $sformatf("s0_type%0d", t));
    end

    apply(LOGIC, 8'b1000_0000, 7'h00,       3'd7, 8'b0000_0001, "logic_max");
    apply(ARITH, 8'b1000_0000, 7'h00,       3'd7, 8'b1111_1111, "arith_max");
    apply(RCR,   8'b1000_0000, 7'b011_0110, 3'd7, 8'b0110_1101, "rcr_max");
    apply(ROR,   8'b1000_0001, 7'h00,       3'd7, 8'b0000_0011, "ror_max");

    // back-to-back sweep: drive every cycle, compare the result one cycle later
    for (int t = 0; t < 4; t++) begin
      for (int s = 0; s < 8; s++) begin
        apply(SHIFT_TYPE'(2'(t)), 8'b1010_0011, 7'b110_1001, 3'(s),
              ref_model(SHIFT_TYPE'(2'(t)), 8'b1010_0011, 7'b110_1001, 3'(s)),
              $sformatf("sweep_t%0d_s%0d", t, s));
      end
    end

    for (int i = 0; i < 24; i++) begin
      logic [7:0] rd;
      logic [6:0] rc;
      logic [2:0] rs;
      logic [1:0] rt;
      rd = 8'($urandom);
      rc = 7'($urandom);
      rs = 3'($urandom_range(0, 7));
      rt = 2'($urandom_range(0, 3));
      apply(SHIFT_TYPE'(rt), rd, rc, rs, ref_model(SHIFT_TYPE'(rt), rd, rc, rs),
            $sformatf("rand%0d", i));
    end

    // inputs changing between edges must not reach the output
    apply(LOGIC, 8'hFF, 7'h00, 3'd0, 8'hFF, "hold_load");
    #2;
    d_in       = 8'h00;
    shift_type = ARITH;
    #1;
    check_eq("hold_between_edges", d_out, 8'hFF);

    // asynchronous reset mid-cycle with a nonzero output
    apply(ROR, 8'b1001_0110, 7'h00, 3'd3, 8'b1101_0010, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_cycle", d_out, 8'h00);
    @(posedge clk);
    #1;
    check_eq("reset_clocked", d_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ARITH, 8'b1001_0110, 7'h00, 3'd3, 8'b1111_0010);
    collect("post_reset_first");
    apply(RCR, 8'b1010_0011, 7'b110_1001, 3'd5, 8'b0100_1101, "post_reset_rcr");

    if (exp_q.size() != 0) begin
      check_eq("sb_leftover", 8'(exp_q.size()), 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
